// File: rtl/c2h_frame_sender_if.sv
// AXI-Stream C2H channel 0 carrying packed frames from the frame sender to the DMA engine.
interface c2h_frame_sender_if;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/c2h_frame_sender.sv
// Splits one 4072-bit packed frame into eight 512-bit AXI-Stream beats, handshakes
// completion back to the packer, and tracks frame/drop counts and sequence continuity.
module c2h_frame_sender (
  input  logic              m_axis_c2h_aclk,
  input  logic              m_axis_c2h_aresetn,
  input  logic              en,
  input  logic              frame_valid,
  input  logic [4071:0]     frame_data,
  output logic              data_next,
  output logic              busy,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       drop_cnt,
  output logic              seq_err,
  c2h_frame_sender_if.master m_axis_c2h_0
);

  localparam int unsigned FRAME_W = 4072;
  localparam int unsigned BEAT_W  = 512;
  localparam int unsigned KEEP_W  = BEAT_W / 8;
  localparam int unsigned PAD_W   = BEAT_W * 8;
  localparam int unsigned SEQ_W   = 8;
  localparam int unsigned IDX_W   = 3;
  localparam logic [KEEP_W-1:0] KEEP_FULL = '1;
  localparam logic [KEEP_W-1:0] KEEP_LAST = 64'h1FFF_FFFF_FFFF_FFFF;
  localparam logic [IDX_W-1:0]  LAST_IDX  = 3'd7;

  typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     beat_idx_q;
  logic [FRAME_W-1:0]   buf_q;
  logic [BEAT_W-1:0]    tdata_q;
  logic [KEEP_W-1:0]    tkeep_q;
  logic                 tvalid_q;
  logic                 tlast_q;
  logic                 data_next_q;
  logic                 busy_q;
  logic [31:0]          frame_cnt_q;
  logic [15:0]          drop_cnt_q;
  logic                 seq_err_q;
  logic [SEQ_W-1:0]     exp_seq_q;

  // Next beat is sliced from the buffer zero-extended to a whole number of beats.
  logic [IDX_W-1:0]     next_idx;
  logic [PAD_W-1:0]     buf_pad;
  logic [11:0]          next_base;
  logic [BEAT_W-1:0]    next_beat;
  logic                 beat_accept;

  assign next_idx    = beat_idx_q + 3'd1;
  assign buf_pad     = {{(PAD_W - FRAME_W){1'b0}}, buf_q};
  assign next_base   = {next_idx, 9'd0};
  assign next_beat   = buf_pad[next_base +: BEAT_W];
  assign beat_accept = tvalid_q && m_axis_c2h_0.tready;

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      state_q     <= IDLE;
      beat_idx_q  <= '0;
      buf_q       <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      data_next_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      seq_err_q   <= 1'b0;
      exp_seq_q   <= '0;
    end else if (en) begin
      state_q     <= IDLE;
      beat_idx_q  <= '0;
      buf_q       <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      data_next_q <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      seq_err_q   <= 1'b0;
      exp_seq_q   <= '0;
    end else begin
      data_next_q <= 1'b0;

      // Frames offered while a previous one is still in flight are discarded.
      if (frame_valid && (state_q != IDLE) && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end

      case (state_q)
        IDLE: begin
          if (frame_valid) begin
            buf_q      <= frame_data;
            beat_idx_q <= '0;
            tdata_q    <= frame_data[BEAT_W-1:0];
            tkeep_q    <= KEEP_FULL;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SEND;
            if (frame_data[SEQ_W-1:0] != exp_seq_q) begin
              seq_err_q <= 1'b1;
            end
            exp_seq_q  <= frame_data[SEQ_W-1:0] + 8'd1;
          end
        end

        SEND: begin
          if (beat_accept) begin
            if (beat_idx_q == LAST_IDX) begin
              tvalid_q    <= 1'b0;
              tlast_q     <= 1'b0;
              data_next_q <= 1'b1;
              state_q     <= ACK;
            end else begin
              beat_idx_q <= next_idx;
              tdata_q    <= next_beat;
              tkeep_q    <= (next_idx == LAST_IDX) ? KEEP_LAST : KEEP_FULL;
              tlast_q    <= (next_idx == LAST_IDX);
            end
          end
        end

        ACK: begin
          frame_cnt_q <= frame_cnt_q + 32'd1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_axis_c2h_0.tdata  = tdata_q;
  assign m_axis_c2h_0.tkeep  = tkeep_q;
  assign m_axis_c2h_0.tvalid = tvalid_q;
  assign m_axis_c2h_0.tlast  = tlast_q;
  assign data_next           = data_next_q;
  assign busy                = busy_q;
  assign frame_cnt           = frame_cnt_q;
  assign drop_cnt            = drop_cnt_q;
  assign seq_err             = seq_err_q;

endmodule
